jk_cmd_driver: RTL
==================

JK_CMD_DRIVER -- requirements
Module: jk_cmd_driver

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, the number of command FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 1, the number of clk cycles j/k are held active per command (1..15).
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 1, the number of clk cycles j=k=0 follows each drive phase (1..15).
REQ-004 SHALL have ports: clk input 1 (sole clock; all state updates on its rising edge); rst input 1 (reset is synchronous and active-high).
REQ-005 SHALL have ports: cmd_valid input 1 (command offered); cmd input 2 (00 hold, 01 clear, 10 set, 11 toggle); cmd_ready output 1 (FIFO can accept).
REQ-006 SHALL have ports: j output 1, k output 1 (registered JK drive to downstream flip-flop).
REQ-007 SHALL have ports: q_fb input 1 (downstream flip-flop out, fed back); busy output 1 (FSM not IDLE or FIFO non-empty).
REQ-008 SHALL have ports: done output 1 (one-cycle pulse per completed command); exp_q output 1 (expected flip-flop state); err output 1 (sticky mismatch flag).

Function
REQ-009 SHALL accept a command on each rising edge where cmd_valid=1 and cmd_ready=1, writing cmd into the FIFO tail.
REQ-010 SHALL drive cmd_ready = not full, combinationally from FIFO count only; a same-cycle pop SHALL NOT raise cmd_ready when full.
REQ-011 SHALL allow simultaneous push and pop when not full; the count is unchanged and ordering is preserved.
REQ-012 SHALL wrap read and write pointers modulo FIFO_DEPTH without loss or duplication.
REQ-013 SHALL implement FSM states IDLE, DRIVE, SETTLE.
REQ-014 IDLE: j=k=0; if FIFO non-empty, pop the head, load {j,k}=cmd, load the phase counter with HOLD_CYCLES-1, go to DRIVE.
REQ-015 DRIVE: hold {j,k}; at counter zero, set j=k=0, load the counter with SETTLE_CYCLES-1, go to SETTLE; otherwise decrement.
REQ-016 SETTLE: j=k=0; at counter zero, pulse done for one cycle, update exp_q, go to IDLE; otherwise decrement.
REQ-017 exp_q update SHALL be: hold keeps, clear 0, set 1, toggle inverts.
REQ-018 Latency SHALL be: command accepted at edge E0 -> j/k valid after E1 -> j=k=0 after E(1+HOLD_CYCLES) -> done high after E(1+HOLD_CYCLES+SETTLE_CYCLES).
REQ-019 Back-to-back queued commands SHALL incur exactly one IDLE cycle between a done pulse and the next drive phase.
REQ-020 With FIFO empty in IDLE, the FSM SHALL remain in IDLE with j=k=0, done=0 and busy=0.
REQ-021 Commands offered while cmd_ready=0 SHALL be dropped by protocol; the sender holds cmd_valid and cmd stable until accepted.

Reset
REQ-022 On rising edge with rst=1, the block SHALL flush the FIFO, enter IDLE and clear the phase counter.
REQ-023 On that reset edge, the block SHALL set j=0, k=0, done=0, exp_q=0, err=0, busy=0 and cmd_ready=1.
REQ-024 Reset mid-DRIVE or mid-SETTLE SHALL abort the command with no done pulse and no exp_q update.
REQ-025 rst SHALL take priority over any same-edge push or pop.
REQ-026 rst SHALL be shared with the downstream flip-flop, so exp_q=0 matches its reset state.

Configuration
REQ-027 With macro JK_CMD_VERIFY_EN defined, on the cycle done pulses, the block SHALL compare q_fb with the updated exp_q and set err=1 on mismatch; err SHALL stay 1 until rst.
REQ-028 Without JK_CMD_VERIFY_EN, err SHALL be constant 0, q_fb SHALL be unused, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then push set (10) with defaults -> j=1,k=0 for 1 cycle starting 2 edges after accept, then done pulse and exp_q=1.
REQ-030 Push 5 commands back-to-back with FIFO_DEPTH=4 and the FSM stalled in DRIVE (HOLD_CYCLES=8) -> cmd_ready=0 after the 4th entry; order is preserved on j/k.
REQ-031 Sequence set, toggle, toggle, clear, hold -> exp_q = 1,0,1,0,0 at the successive done pulses.
REQ-032 Assert rst during DRIVE of a toggle -> j=k=0 next cycle, no done pulse, exp_q=0, FIFO empty, cmd_ready=1.
REQ-033 JK_CMD_VERIFY_EN defined, q_fb forced 0 during a set command -> err=1 on the done cycle and held until rst; undefined -> err stays 0.
REQ-034 HOLD_CYCLES=3, SETTLE_CYCLES=2, with push and pop on the same cycle at count 2 -> count stays 2; j/k active exactly 3 cycles, done 5 cycles after the pop.

Source files
------------

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: queues 2-bit JK commands and plays each onto j/k for HOLD_CYCLES, then
// holds j=k=0 for SETTLE_CYCLES before pulsing done. JK_CMD_VERIFY_EN enables the q_fb check.
module jk_cmd_driver #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  input  logic       q_fb,
  output logic       busy,
  output logic       done,
  output logic       exp_q,
  output logic       err
);

  localparam int unsigned AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [1:0]      mem_d [FIFO_DEPTH];
  logic [1:0]      jk_q, jk_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            done_q, done_d;
  logic            exp_state_q, exp_state_d;

  logic            push;
  logic            pop;
  logic            settle_last;
  logic            exp_next;
  logic [1:0]      head;

  // Ready looks only at the registered count so a same-cycle pop never opens a full FIFO.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // FIFO storage and pointers; pointers wrap naturally because depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
          cnt_d   = HOLD_LOAD;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign settle_last = (state_q == SETTLE) && (cnt_q == '0);

  always_comb begin
    case (cmd_q)
      2'b00:   exp_next = exp_state_q;
      2'b01:   exp_next = 1'b0;
      2'b10:   exp_next = 1'b1;
      default: exp_next = ~exp_state_q;
    endcase
  end

  // Output logic; j/k, done and exp_q are all registered.
  always_comb begin
    jk_d        = jk_q;
    cmd_d       = cmd_q;
    done_d      = 1'b0;
    exp_state_d = exp_state_q;
    case (state_q)
      IDLE: begin
        jk_d = '0;
        if (pop) begin
          jk_d  = head;
          cmd_d = head;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          jk_d = '0;
        end
      end
      SETTLE: begin
        jk_d = '0;
        if (settle_last) begin
          done_d      = 1'b1;
          exp_state_d = exp_next;
        end
      end
      default: begin
        jk_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      jk_q        <= '0;
      cmd_q       <= '0;
      done_q      <= 1'b0;
      exp_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      jk_q        <= jk_d;
      cmd_q       <= cmd_d;
      done_q      <= done_d;
      exp_state_q <= exp_state_d;
    end
  end

  assign j     = jk_q[1];
  assign k     = jk_q[0];
  assign done  = done_q;
  assign exp_q = exp_state_q;
  assign busy  = (state_q != IDLE) || (count_q != '0);

`ifdef JK_CMD_VERIFY_EN
  logic err_q, err_d;

  // q_fb is sampled on the final settle edge so err rises together with done.
  always_comb begin
    err_d = err_q;
    if (settle_last && (q_fb != exp_next)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule
